// File: rtl/hough_pkg.sv
// Shared types and elaboration-time helpers for the Hough vote generator.
//   state_e     : sweep FSM states
//   prod_width  : width of the signed x*cos / y*sin products
//   trig_fixed  : degrees (0..179) -> round(cos or sin * 2^frac_bits), signed
package hough_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain
    } state_e;

    function automatic int unsigned prod_width(input int unsigned x_w,
                                               input int unsigned frac_bits);
        return x_w + 1 + frac_bits + 2;
    endfunction

    // sin(deg) for 0..90 degrees in Q30, Taylor series evaluated with integers so the
    // table is a pure elaboration-time constant.
    function automatic longint sin_q30(input int deg);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (longint'(deg) * 64'sd3373259426) / 64'sd180; // deg * pi/180 in Q30
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        if (sum < 0) begin
            sum = 0;
        end
        return sum;
    endfunction

    function automatic int trig_fixed(input int deg, input int frac_bits, input bit want_sin);
        longint v;
        longint r;
        bit     neg;
        neg = 1'b0;
        if (want_sin) begin
            v = sin_q30((deg <= 90) ? deg : 180 - deg);
        end else if (deg <= 90) begin
            v = sin_q30(90 - deg);
        end else begin
            v   = sin_q30(deg - 90);
            neg = 1'b1;
        end
        // Round to nearest on the magnitude, then restore the sign.
        r = (v + (64'sd1 <<< (29 - frac_bits))) >>> (30 - frac_bits);
        return neg ? -int'(r) : int'(r);
    endfunction

endpackage

// File: rtl/hough_vote_generator_trig_lookup.sv
// Combinational cos/sin lookup.
//   deg_i : angle in degrees, valid 0..179 (others return 0)
//   cos_o : round(cos * 2^FRAC_BITS), signed FRAC_BITS+2 bits
//   sin_o : round(sin * 2^FRAC_BITS), signed FRAC_BITS+2 bits
module trig_lookup
    import hough_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic [7:0]                  deg_i,
    output logic signed [FRAC_BITS+1:0] cos_o,
    output logic signed [FRAC_BITS+1:0] sin_o
);

    localparam int unsigned TW = FRAC_BITS + 2;

    logic signed [TW-1:0] cos_tbl [180];
    logic signed [TW-1:0] sin_tbl [180];

    for (genvar g = 0; g < 180; g++) begin : g_tbl
        localparam int CosV = trig_fixed(g, int'(FRAC_BITS), 1'b0);
        localparam int SinV = trig_fixed(g, int'(FRAC_BITS), 1'b1);
        assign cos_tbl[g] = TW'(CosV);
        assign sin_tbl[g] = TW'(SinV);
    end

    always_comb begin
        cos_o = '0;
        sin_o = '0;
        if (deg_i < 8'd180) begin
            cos_o = cos_tbl[deg_i];
            sin_o = sin_tbl[deg_i];
        end
    end

endmodule

// File: rtl/hough_vote_generator.sv
// Hough-space vote generator: accepts one edge pixel per handshake and streams
// N_ANGLES votes (angle, rho = x*cos + y*sin) through a two-stage pipeline.
//   pt_valid_i/pt_ready_o/pt_x_i/pt_y_i : input point handshake
//   flush_i                             : synchronous abort of the current sweep
//   vote_valid_o/vote_ready_i           : output vote handshake
//   vote_angle_o/vote_rho_o/vote_last_o : vote payload
//   done_o                              : one-cycle pulse after the last vote handshake
module hough_vote_generator
    import hough_pkg::*;
#(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned N_ANGLES   = 45,
    parameter int unsigned ANGLE_STEP = 4,
    parameter int unsigned FRAC_BITS  = 12,
    parameter int unsigned RHO_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pt_valid_i,
    output logic                    pt_ready_o,
    input  logic [X_W-1:0]          pt_x_i,
    input  logic [Y_W-1:0]          pt_y_i,
    input  logic                    flush_i,
    output logic                    vote_valid_o,
    input  logic                    vote_ready_i,
    output logic [7:0]              vote_angle_o,
    output logic signed [RHO_W-1:0] vote_rho_o,
    output logic                    vote_last_o,
    output logic                    done_o
);

    localparam int unsigned PW = prod_width(X_W, FRAC_BITS);
    localparam int unsigned TW = FRAC_BITS + 2;
    localparam int unsigned KW = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1;
    localparam logic [KW-1:0] KLast = KW'(N_ANGLES - 1);

    state_e st_q, st_d;
    logic [KW-1:0]  k_q, k_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;
    logic [7:0]           s1_angle_q, s1_angle_d;
    logic signed [PW-1:0] s1_px_q, s1_px_d;
    logic signed [PW-1:0] s1_py_q, s1_py_d;

    logic                    vote_valid_q, vote_valid_d;
    logic                    vote_last_q, vote_last_d;
    logic [7:0]              vote_angle_q, vote_angle_d;
    logic signed [RHO_W-1:0] vote_rho_q, vote_rho_d;
    logic                    done_q, done_d;

    logic [7:0]           k_angle;
    logic signed [TW-1:0] cos_w, sin_w;
    logic signed [PW-1:0] x_ext, y_ext, cos_ext, sin_ext;
    logic signed [PW-1:0] prod_x, prod_y;
    logic signed [PW:0]   rho_sum, rho_shift;
    logic                 adv, issue, last_hs;

    assign k_angle = 8'(32'(k_q) * ANGLE_STEP);

    trig_lookup #(
        .FRAC_BITS(FRAC_BITS)
    ) u_trig (
        .deg_i(k_angle),
        .cos_o(cos_w),
        .sin_o(sin_w)
    );

    // Pixel coordinates are unsigned: zero-extend, trig values sign-extend.
    assign x_ext   = {{(PW - X_W){1'b0}}, x_q};
    assign y_ext   = {{(PW - Y_W){1'b0}}, y_q};
    assign cos_ext = {{(PW - TW){cos_w[TW-1]}}, cos_w};
    assign sin_ext = {{(PW - TW){sin_w[TW-1]}}, sin_w};
    assign prod_x  = x_ext * cos_ext;
    assign prod_y  = y_ext * sin_ext;

    assign rho_sum   = $signed({s1_px_q[PW-1], s1_px_q}) + $signed({s1_py_q[PW-1], s1_py_q});
    assign rho_shift = rho_sum >>> FRAC_BITS;

    // Whole pipeline (and k) freezes while an output vote is refused.
    assign adv     = ~(vote_valid_q & ~vote_ready_i);
    assign issue   = (st_q == StSweep) & adv;
    assign last_hs = vote_valid_q & vote_ready_i & vote_last_q;

    always_comb begin
        st_d         = st_q;
        k_d          = k_q;
        x_d          = x_q;
        y_d          = y_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_angle_d   = s1_angle_q;
        s1_px_d      = s1_px_q;
        s1_py_d      = s1_py_q;
        vote_valid_d = vote_valid_q;
        vote_last_d  = vote_last_q;
        vote_angle_d = vote_angle_q;
        vote_rho_d   = vote_rho_q;
        done_d       = 1'b0;

        case (st_q)
            StIdle: begin
                if (pt_valid_i) begin
                    x_d  = pt_x_i;
                    y_d  = pt_y_i;
                    k_d  = '0;
                    st_d = StSweep;
                end
            end
            StSweep: begin
                if (adv) begin
                    if (k_q == KLast) begin
                        k_d  = '0;
                        st_d = StDrain;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (last_hs) begin
                    st_d   = StIdle;
                    done_d = 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase

        if (adv) begin
            s1_valid_d = issue;
            if (issue) begin
                s1_last_d  = (k_q == KLast);
                s1_angle_d = k_angle;
                s1_px_d    = prod_x;
                s1_py_d    = prod_y;
            end
            vote_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                vote_last_d  = s1_last_q;
                vote_angle_d = s1_angle_q;
                vote_rho_d   = rho_shift[RHO_W-1:0];
            end else begin
                vote_last_d = 1'b0;
            end
        end

        // Flush wins over everything, including a simultaneous point offer.
        if (flush_i) begin
            st_d         = StIdle;
            k_d          = '0;
            s1_valid_d   = 1'b0;
            s1_last_d    = 1'b0;
            vote_valid_d = 1'b0;
            vote_last_d  = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= StIdle;
            k_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_angle_q   <= '0;
            s1_px_q      <= '0;
            s1_py_q      <= '0;
            vote_valid_q <= 1'b0;
            vote_last_q  <= 1'b0;
            vote_angle_q <= '0;
            vote_rho_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            st_q         <= st_d;
            k_q          <= k_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_angle_q   <= s1_angle_d;
            s1_px_q      <= s1_px_d;
            s1_py_q      <= s1_py_d;
            vote_valid_q <= vote_valid_d;
            vote_last_q  <= vote_last_d;
            vote_angle_q <= vote_angle_d;
            vote_rho_q   <= vote_rho_d;
            done_q       <= done_d;
        end
    end

    assign pt_ready_o   = (st_q == StIdle);
    assign vote_valid_o = vote_valid_q;
    assign vote_last_o  = vote_last_q;
    assign vote_angle_o = vote_angle_q;
    assign vote_rho_o   = vote_rho_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_hough_vote_generator.sv
// Directed self-checking bench for hough_vote_generator (default parameters).
module tb_hough_vote_generator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pt_valid;
    logic              pt_ready;
    logic [9:0]        pt_x;
    logic [8:0]        pt_y;
    logic              flush;
    logic              vote_valid;
    logic              vote_ready;
    logic [7:0]        vote_angle;
    logic signed [11:0] vote_rho;
    logic              vote_last;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hough_vote_generator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pt_valid_i  (pt_valid),
        .pt_ready_o  (pt_ready),
        .pt_x_i      (pt_x),
        .pt_y_i      (pt_y),
        .flush_i     (flush),
        .vote_valid_o(vote_valid),
        .vote_ready_i(vote_ready),
        .vote_angle_o(vote_angle),
        .vote_rho_o  (vote_rho),
        .vote_last_o (vote_last),
        .done_o      (done)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference trig from real math, rounded to 12 fraction bits.
    function automatic int ref_trig(input int deg, input bit want_sin);
        real rad;
        real v;
        rad = real'(deg) * 3.14159265358979 / 180.0;
        v   = want_sin ? $sin(rad) : $cos(rad);
        return $rtoi($floor(v * 4096.0 + 0.5));
    endfunction

    function automatic int exp_rho(input int x, input int y, input int k);
        int s;
        s = x * ref_trig(k * 4, 1'b0) + y * ref_trig(k * 4, 1'b1);
        return s >>> 12;
    endfunction

    // Offers a point at a negedge; returns at the negedge after the accepting edge.
    task automatic send_point(input int x, input int y);
        check("pt_ready_before_accept", pt_ready, 1);
        pt_valid = 1'b1;
        pt_x     = 10'(x);
        pt_y     = 9'(y);
        @(negedge clk);
        pt_valid = 1'b0;
        check("pt_ready_after_accept", pt_ready, 0);
    endtask

    // Consumes votes, checking each against the model. stop_after>0 raises flush after
    // that many handshakes and returns immediately.
    task automatic collect(input int x, input int y, input bit rnd, input int stop_after,
                           output int r0, output int r1, output int rl);
        int          k;
        int          cyc;
        bit          held;
        bit          finished;
        logic [7:0]  pa;
        logic signed [11:0] pr;
        logic        pl;
        k = 0; cyc = 0; held = 0; finished = 0;
        r0 = 0; r1 = 0; rl = 0;
        pa = '0; pr = '0; pl = 1'b0;
        while (!finished && cyc < 3000) begin
            if (stop_after > 0 && k == stop_after) begin
                flush      = 1'b1;
                vote_ready = 1'b0;
                return;
            end
            check("done_low_in_sweep", done, 0);
            check("pt_ready_low_in_sweep", pt_ready, 0);
            if (held) begin
                check("stall_valid_held", vote_valid, 1);
                check("stall_angle_stable", vote_angle, pa);
                check("stall_rho_stable", vote_rho, pr);
                check("stall_last_stable", vote_last, pl);
            end
            vote_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (vote_valid && vote_ready) begin
                check("vote_angle", vote_angle, k * 4);
                check("vote_rho", vote_rho, exp_rho(x, y, k));
                check("vote_last", vote_last, (k == 44));
                if (k == 0) r0 = vote_rho;
                if (k == 1) r1 = vote_rho;
                if (k == 44) rl = vote_rho;
                if (vote_last) finished = 1;
                k++;
                held = 0;
            end else begin
                held = vote_valid;
                pa   = vote_angle;
                pr   = vote_rho;
                pl   = vote_last;
            end
            @(negedge clk);
            cyc++;
        end
        if (stop_after == 0) begin
            check("vote_count", k, 45);
            check("done_after_last", done, 1);
            check("pt_ready_with_done", pt_ready, 1);
            check("valid_low_after_last", vote_valid, 0);
            @(negedge clk);
            check("done_single_cycle", done, 0);
        end
    endtask

    initial begin
        int r0, r1, rl;
        rst_n      = 1'b0;
        pt_valid   = 1'b0;
        pt_x       = '0;
        pt_y       = '0;
        flush      = 1'b0;
        vote_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        check("rst_angle", vote_angle, 0);
        check("rst_rho", vote_rho, 0);
        check("rst_last", vote_last, 0);
        for (int i = 0; i < 10; i++) begin
            check("rst_pt_ready", pt_ready, 1);
            check("rst_vote_valid", vote_valid, 0);
            check("rst_done", done, 0);
            @(negedge clk);
        end

        // x=100, y=0 with no backpressure; latency 2.
        send_point(100, 0);
        check("latency_e0", vote_valid, 0);
        @(negedge clk);
        check("latency_e1", vote_valid, 0);
        @(negedge clk);
        check("latency_e2", vote_valid, 1);
        collect(100, 0, 1'b0, 0, r0, r1, rl);
        check("x100_angle0_rho", r0, 100);
        check("x100_angle4_rho", r1, 99);
        check("x100_angle176_rho", rl, -100);

        // Corner pixel with no backpressure.
        send_point(1023, 511);
        collect(1023, 511, 1'b0, 0, r0, r1, rl);
        check("corner_angle0_rho", r0, 1023);
        check("corner_angle176_rho", rl, -985);

        // Corner pixel with pseudo-random backpressure.
        send_point(1023, 511);
        collect(1023, 511, 1'b1, 0, r0, r1, rl);
        check("bp_angle0_rho", r0, 1023);
        check("bp_angle176_rho", rl, -985);

        // Flush after the 10th vote.
        send_point(640, 300);
        collect(640, 300, 1'b0, 10, r0, r1, rl);
        @(negedge clk);
        flush      = 1'b0;
        vote_ready = 1'b1;
        check("flush_pt_ready", pt_ready, 1);
        check("flush_valid", vote_valid, 0);
        check("flush_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_flush_valid", vote_valid, 0);
            check("post_flush_done", done, 0);
        end
        send_point(640, 300);
        collect(640, 300, 1'b0, 0, r0, r1, rl);
        check("after_flush_angle0_rho", r0, 640);

        // Flush overrides a simultaneous point offer in idle.
        pt_valid = 1'b1;
        pt_x     = 10'd200;
        pt_y     = 9'd100;
        flush    = 1'b1;
        @(negedge clk);
        pt_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept", pt_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_blocks_votes", vote_valid, 0);
        end

        // Reset mid-sweep.
        send_point(300, 200);
        repeat (6) @(negedge clk);
        check("pre_reset_valid", vote_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pt_ready", pt_ready, 1);
        check("mid_rst_valid", vote_valid, 0);
        check("mid_rst_last", vote_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_angle", vote_angle, 0);
        check("mid_rst_rho", vote_rho, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_point(50, 400);
        collect(50, 400, 1'b0, 0, r0, r1, rl);
        check("post_rst_angle0_rho", r0, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
